issue_scheduler: RTL

- Single-issue scheduler for the shared ALU execution unit.
- Arbitrates each cycle among N execution-buffer issue requests and grants at most one, round-robin.
- Ops have variable latency, so it keeps a writeback-slot reservation table: no two granted ops may complete in the same cycle on the single result/wakeup bus.
- Sits between the execution buffers (requesters) and the ALU/writeback stage; also drives the writeback tag used for operand wakeup.

---
 rtl/issue_scheduler_if.sv | 28 ++
 rtl/issue_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler_if.sv
// Issue/writeback bundle between the execution buffers and the ALU issue
// scheduler. master = requester side, slave = scheduler side.
interface issue_scheduler_if #(
  parameter int N     = 4,
  parameter int LAT_W = 3
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]       req;
  logic [N*LAT_W-1:0] req_lat;
  logic               ex_stall;
  logic               flush;
  logic [N-1:0]       grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               issue_valid;
  logic               wb_valid;
  logic [IDX_W-1:0]   wb_idx;

  modport master (
    output req, req_lat, ex_stall, flush,
    input  grant, grant_idx, issue_valid, wb_valid, wb_idx
  );

  modport slave (
    input  req, req_lat, ex_stall, flush,
    output grant, grant_idx, issue_valid, wb_valid, wb_idx
  );
endinterface

// File: rtl/issue_scheduler.sv
// Single-issue round-robin scheduler for the shared ALU. A writeback-slot
// reservation table (busy/tag, entry k = writeback k cycles from now) keeps
// two granted ops from completing in the same cycle on the result bus.
// Optional feature macro: ISSUE_SCHED_STARVE_EN (per-requester denial
// counters that force priority to the lowest-index starving requester).
module issue_scheduler #(
  parameter int N            = 4,
  parameter int MAX_LAT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              n_rst,
  issue_scheduler_if.slave bus
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int IDX_W = $clog2(N);
  localparam int SLOTS = 1 << LAT_W;

  logic [MAX_LAT-1:0]            busy_reg, busy_next;
  logic [MAX_LAT-1:0][IDX_W-1:0] tag_reg, tag_next;
  logic [IDX_W-1:0]              rr_ptr_reg, rr_ptr_next;
  logic [N-1:0][LAT_W-1:0]       lat;
  logic [SLOTS-1:0]              slot_free;
  logic [N-1:0]                  eligible;
  logic [N-1:0]                  cand;
  logic [N-1:0]                  grant_vec;
  logic                          issue_ok;
  logic                          grant_valid;
  logic [IDX_W-1:0]              sel_idx;
  logic [LAT_W-1:0]              sel_lat;

  genvar gi;

  // Slot L is usable by a latency-L op when busy[L] is clear (that entry
  // becomes busy[L-1] after this cycle's shift). Slot MAX_LAT is always
  // free; latency 0 and anything above MAX_LAT map to a never-free slot.
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi == 0) begin : g_zero
        assign slot_free[gi] = 1'b0;
      end else if (gi < MAX_LAT) begin : g_table
        assign slot_free[gi] = ~busy_reg[gi];
      end else if (gi == MAX_LAT) begin : g_top
        assign slot_free[gi] = 1'b1;
      end else begin : g_invalid
        assign slot_free[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_req
      assign lat[gi]      = bus.req_lat[gi*LAT_W +: LAT_W];
      assign eligible[gi] = bus.req[gi] & slot_free[lat[gi]];
    end
  endgenerate

`ifdef ISSUE_SCHED_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N-1:0][CNT_W-1:0] cnt_reg, cnt_next;
  logic [N-1:0]            starving;
  logic [N-1:0]            force_mask;

  generate
    for (gi = 0; gi < N; gi++) begin : g_starve
      assign starving[gi] = (cnt_reg[gi] >= CNT_W'(STARVE_LIMIT));
    end
  endgenerate

  // Restrict candidates to the lowest-index starving requester, if any.
  always_comb begin
    force_mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (starving[i]) begin
        force_mask    = '0;
        force_mask[i] = 1'b1;
      end
    end
    cand = (|starving) ? (eligible & force_mask) : eligible;
  end

  // Denial counters: count up while requesting and not granted, saturate.
  always_comb begin
    cnt_next = cnt_reg;
    for (int i = 0; i < N; i++) begin
      if (bus.flush || grant_vec[i] || !bus.req[i]) begin
        cnt_next[i] = '0;
      end else if (cnt_reg[i] < CNT_W'(STARVE_LIMIT)) begin
        cnt_next[i] = cnt_reg[i] + 1'b1;
      end
    end
  end

  // Denial counter register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign cand = eligible;
`endif

  assign issue_ok = n_rst & ~bus.ex_stall & ~bus.flush;

  // Round-robin pick: first candidate scanning rr_ptr, rr_ptr+1, ... mod N.
  always_comb begin
    int j;
    grant_valid = 1'b0;
    sel_idx     = '0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr_reg) + k;
      if (j >= N) j = j - N;
      if (issue_ok && !grant_valid && cand[j]) begin
        grant_valid = 1'b1;
        sel_idx     = IDX_W'(j);
      end
    end
  end

  assign sel_lat = lat[sel_idx];

  // One-hot grant vector from the selected index.
  always_comb begin
    grant_vec = '0;
    if (grant_valid) grant_vec[sel_idx] = 1'b1;
  end

  // Table shift plus reservation for the granted op; flush empties it.
  always_comb begin
    busy_next   = busy_reg >> 1;
    tag_next    = tag_reg >> IDX_W;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (grant_valid && sel_lat == LAT_W'(k + 1)) begin
        busy_next[k] = 1'b1;
        tag_next[k]  = sel_idx;
      end
    end
    if (grant_valid) begin
      rr_ptr_next = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + 1'b1;
    end
    if (bus.flush) begin
      busy_next = '0;
      tag_next  = '0;
    end
  end

  // Reservation table and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      busy_reg   <= '0;
      tag_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      busy_reg   <= busy_next;
      tag_reg    <= tag_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign bus.grant       = grant_vec;
  assign bus.grant_idx   = grant_valid ? sel_idx : '0;
  assign bus.issue_valid = grant_valid;
  assign bus.wb_valid    = n_rst & busy_reg[0];
  assign bus.wb_idx      = n_rst ? tag_reg[0] : '0;
endmodule
